// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/subtract result FIFO.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package addsub_pkg;

    // One stored result: value plus the flags captured at push time.
    typedef struct packed {
        logic [3:0] res;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
    } entry_t;

    // Occupancy classes, derived from the FIFO count.
    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_e;

    localparam int         DEPTH_DEFAULT = 4;
    localparam logic [3:0] SAT_POS       = 4'b0111;
    localparam logic [3:0] SAT_NEG       = 4'b1000;

endpackage

// File: rtl/addsub_flag_gen.sv
// Builds a FIFO entry (result + c/z/n/v flags) from a raw adder/subtractor result.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake, evaluated every cycle.
// Optional macro ADDSUB_RESULT_SAT_EN clamps overflowed results to the signed limit.
module addsub_flag_gen
    import addsub_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       sub_i,
    input  logic [3:0] res_i,
    input  logic       cout_i,
    output entry_t     ent_o
);

    logic       v_raw;
    logic [3:0] res_f;
    // Only the operand sign bits matter for the flags.
    logic       unused_operand_bits;

    assign unused_operand_bits = ^{a_i[2:0], b_i[2:0]};

    // Flag derivation; z/n follow the stored value, c/v describe the raw operation.
    always_comb begin
        v_raw = (a_i[3] == (b_i[3] ^ sub_i)) && (res_i[3] != a_i[3]);
`ifdef ADDSUB_RESULT_SAT_EN
        if (v_raw) begin
            res_f = a_i[3] ? SAT_NEG : SAT_POS;
        end else begin
            res_f = res_i;
        end
`else
        res_f = res_i;
`endif
        ent_o.res = res_f;
        ent_o.c   = cout_i ^ sub_i;
        ent_o.z   = (res_f == 4'd0);
        ent_o.n   = res_f[3];
        ent_o.v   = v_raw;
    end

endmodule

// File: rtl/addsub_result_fifo.sv
// Small FIFO that captures add/subtract results with flags computed at push time.
// Latency: one cycle from push into an empty FIFO to out_valid.
// Backpressure: in_ready = not full (no full-state bypass); out_valid = not empty.
// Optional macro ADDSUB_RESULT_SAT_EN enables saturation of overflowed results.
module addsub_result_fifo
    import addsub_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_a,
    input  logic [3:0]               in_b,
    input  logic                     in_sub,
    input  logic [3:0]               in_res,
    input  logic                     in_cout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_res,
    output logic                     out_c,
    output logic                     out_z,
    output logic                     out_n,
    output logic                     out_v,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int             AW       = $clog2(DEPTH);
    localparam int             CW       = AW + 1;
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

    entry_t          mem_q [DEPTH];
    entry_t          in_ent;
    entry_t          head;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    occ_e            occ;
    logic            push;
    logic            pop;

    addsub_flag_gen u_flag_gen (
        .a_i    (in_a),
        .b_i    (in_b),
        .sub_i  (in_sub),
        .res_i  (in_res),
        .cout_i (in_cout),
        .ent_o  (in_ent)
    );

    // Occupancy class and handshakes, all derived from the registered count.
    always_comb begin
        occ = OCC_PARTIAL;
        if (count_q == '0) begin
            occ = OCC_EMPTY;
        end else if (count_q == FULL_CNT) begin
            occ = OCC_FULL;
        end
        in_ready  = (occ != OCC_FULL);
        out_valid = (occ != OCC_EMPTY);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Next-state pointers and count; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset discards every stored entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are left alone by reset since pointers invalidate them.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= in_ent;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign out_res   = head.res;
    assign out_c     = head.c;
    assign out_z     = head.z;
    assign out_n     = head.n;
    assign out_v     = head.v;
    assign count     = count_q;

endmodule
